// File: rtl/bus_pkg.sv
// Shared encodings for the serial bus master: transaction types, beat kinds, FSM states.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package bus_pkg;

    // CPU transaction types (mtype)
    localparam logic [1:0] MT_RDATA = 2'd0;
    localparam logic [1:0] MT_WDATA = 2'd1;
    localparam logic [1:0] MT_RCHAR = 2'd2;
    localparam logic [1:0] MT_WCHAR = 2'd3;

    // bus_ctrl beat kinds; address beats are {1'b0, byte_index}
    localparam logic [2:0] CTRL_IDLE  = 3'b000;
    localparam logic [2:0] CTRL_RDATA = 3'b100;
    localparam logic [2:0] CTRL_WDATA = 3'b101;
    localparam logic [2:0] CTRL_RCHAR = 3'b110;
    localparam logic [2:0] CTRL_WCHAR = 3'b111;

    // Handshake FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PREP    = 3'd1;
    localparam logic [2:0] ST_BEAT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Beat index 0..3 selects an address byte; this value is the data beat
    localparam logic [2:0] DATA_BEAT = 3'd4;

    // Memory transactions carry address beats; char I/O does not
    function automatic logic is_mem(input logic [1:0] mt);
        return ~mt[1];
    endfunction

    // Write types drive the data beat onto the pins
    function automatic logic is_write(input logic [1:0] mt);
        return mt[0];
    endfunction

    function automatic logic [2:0] beat_ctrl(input logic [2:0] beat, input logic [1:0] mt);
        return (beat == DATA_BEAT) ? {1'b1, mt} : {1'b0, beat[1:0]};
    endfunction

endpackage

// File: rtl/bus_beat_seq.sv
// Beat list sequencer: first/next beat index, last-beat flag, optional address-byte skip cache.
// Latency: combinational beat selection; cache updates one cycle after the write strobe.
// Backpressure: none of its own; the handshake FSM decides when to advance.
module bus_beat_seq
    import bus_pkg::*;
#(
    parameter int BUS_W = 8,
    parameter int NA    = 3
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NA*BUS_W-1:0] addr_i,
    input  logic                mem_i,
    input  logic [2:0]          cur_i,
    input  logic                cache_wr_i,
    input  logic                cache_clr_i,
    output logic [2:0]          first_o,
    output logic [2:0]          next_o,
    output logic                last_o
);

    logic [NA-1:0] skip;

    // Lowest unskipped address byte at or above start, else the data beat
    function automatic logic [2:0] next_from(input logic [2:0] start, input logic [NA-1:0] sk);
        logic [2:0] r;
        r = DATA_BEAT;
        for (int i = NA - 1; i >= 0; i--) begin
            if (i >= int'(start) && !sk[i]) r = 3'(i);
        end
        return r;
    endfunction

`ifdef BUSCTL_ADDR_CACHE_EN
    logic [NA*BUS_W-1:0] cache_q;
    logic [NA-1:0]       vld_q;

    // A byte may be skipped only when it is known to already sit in the slave
    always_comb begin
        skip = '0;
        for (int i = 0; i < NA; i++) begin
            skip[i] = mem_i && vld_q[i] && (cache_q[i*BUS_W +: BUS_W] == addr_i[i*BUS_W +: BUS_W]);
        end
    end

    // Record an address byte once its beat is acknowledged; forget all on timeout
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vld_q   <= '0;
            cache_q <= '0;
        end else if (cache_clr_i) begin
            vld_q <= '0;
        end else if (cache_wr_i) begin
            for (int i = 0; i < NA; i++) begin
                if (cur_i == 3'(i)) begin
                    vld_q[i]                  <= 1'b1;
                    cache_q[i*BUS_W +: BUS_W] <= addr_i[i*BUS_W +: BUS_W];
                end
            end
        end
    end
`else
    assign skip = '0;
    logic unused_cache;
    assign unused_cache = ^{clk_i, rst_n_i, addr_i, cache_wr_i, cache_clr_i};
`endif

    assign first_o = mem_i ? next_from(3'd0, skip) : DATA_BEAT;
    assign next_o  = next_from(cur_i + 3'd1, skip);
    assign last_o  = (cur_i == DATA_BEAT);

endmodule

// File: rtl/bus_ser_master.sv
// Serialises a CPU request into address beats plus one data beat over a four-phase rdy/ack bus; BUSCTL_ADDR_CACHE_EN skips unchanged address bytes.
// Latency: 2 + 2*beats cycles from mreq edge to mdone with a 1-cycle slave.
// Backpressure: each beat waits for ack high then low; a wait longer than TIMEOUT cycles aborts with merr.
module bus_ser_master
    import bus_pkg::*;
#(
    parameter int BUS_W   = 8,
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  wdata,
    input  logic [1:0]        mtype,
    input  logic              mreq,
    output logic              mdone,
    output logic              merr,
    output logic [BUS_W-1:0]  rdata,
    output logic [BUS_W-1:0]  bus_out,
    output logic              bus_oe,
    input  logic [BUS_W-1:0]  bus_in,
    output logic              rdy,
    input  logic              ack,
    output logic [2:0]        bus_ctrl
);

    localparam int NA = ADDR_W / BUS_W;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [2:0]        state_q, state_d;
    logic              mreq_dly_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0]  wdata_q, wdata_d;
    logic [1:0]        mtype_q, mtype_d;
    logic [2:0]        beat_q, beat_d;
    logic              rdy_q, rdy_d, oe_q, oe_d, mdone_q, mdone_d, merr_q, merr_d;
    logic [BUS_W-1:0]  out_q, out_d, rdata_q, rdata_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;

    logic [2:0]       first_beat, next_beat, load_beat, load_ctrl;
    logic             last_beat, load_oe, rise, wait_tmo, cache_wr, cache_clr, go_beat, abort;
    logic [BUS_W-1:0] load_out;

    function automatic logic [BUS_W-1:0] addr_byte(input logic [ADDR_W-1:0] a, input logic [2:0] idx);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int i = 0; i < NA; i++) begin
            if (idx == 3'(i)) r = a[i*BUS_W +: BUS_W];
        end
        return r;
    endfunction

    bus_beat_seq #(.BUS_W(BUS_W), .NA(NA)) u_seq (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .addr_i      (addr_q),
        .mem_i       (is_mem(mtype_q)),
        .cur_i       (beat_q),
        .cache_wr_i  (cache_wr),
        .cache_clr_i (cache_clr),
        .first_o     (first_beat),
        .next_o      (next_beat),
        .last_o      (last_beat)
    );

    assign rise      = mreq & ~mreq_dly_q;
    assign wait_tmo  = (TIMEOUT > 0) && (int'(cnt_q) == TIMEOUT - 1);
    assign cnt_inc   = (int'(cnt_q) < TIMEOUT) ? cnt_q + CW'(1) : cnt_q;
    assign load_beat = (state_q == ST_PREP) ? first_beat : next_beat;
    assign load_ctrl = beat_ctrl(load_beat, mtype_q);
    assign load_oe   = (load_beat != DATA_BEAT) || is_write(mtype_q);
    assign load_out  = (load_beat != DATA_BEAT) ? addr_byte(addr_q, load_beat)
                     : (is_write(mtype_q) ? wdata_q : '0);

    // Handshake FSM: next state, beat loading and timeout abort
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mtype_d   = mtype_q;
        beat_d    = beat_q;
        rdy_d     = rdy_q;
        oe_d      = oe_q;
        out_d     = out_q;
        ctrl_d    = ctrl_q;
        mdone_d   = mdone_q;
        merr_d    = merr_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        cache_wr  = 1'b0;
        cache_clr = 1'b0;
        go_beat   = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    mtype_d = mtype;
                    cnt_d   = '0;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                if (!ack)          go_beat = 1'b1;
                else if (wait_tmo) abort   = 1'b1;
                else               cnt_d   = cnt_inc;
            end
            ST_BEAT: begin
                if (ack) begin
                    rdy_d = 1'b0;
                    oe_d  = 1'b0;
                    if (beat_q == DATA_BEAT && !is_write(mtype_q)) rdata_d = bus_in;
                    cache_wr = (beat_q != DATA_BEAT);
                    cnt_d    = '0;
                    state_d  = ST_RELEASE;
                end else if (wait_tmo) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!ack) begin
                    if (last_beat) begin
                        mdone_d = 1'b1;
                        ctrl_d  = CTRL_IDLE;
                        state_d = ST_DONE;
                    end else begin
                        go_beat = 1'b1;
                    end
                end else if (wait_tmo) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                if (!mreq) begin
                    mdone_d = 1'b0;
                    merr_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (go_beat) begin
            beat_d  = load_beat;
            rdy_d   = 1'b1;
            oe_d    = load_oe;
            out_d   = load_out;
            ctrl_d  = load_ctrl;
            cnt_d   = '0;
            state_d = ST_BEAT;
        end
        if (abort) begin
            rdy_d     = 1'b0;
            oe_d      = 1'b0;
            ctrl_d    = CTRL_IDLE;
            mdone_d   = 1'b1;
            merr_d    = 1'b1;
            cache_clr = 1'b1;
            state_d   = ST_DONE;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mreq_dly_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mtype_q    <= '0;
            beat_q     <= '0;
            rdy_q      <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= '0;
            ctrl_q     <= CTRL_IDLE;
            mdone_q    <= 1'b0;
            merr_q     <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mreq_dly_q <= mreq;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mtype_q    <= mtype_d;
            beat_q     <= beat_d;
            rdy_q      <= rdy_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            ctrl_q     <= ctrl_d;
            mdone_q    <= mdone_d;
            merr_q     <= merr_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rdy      = rdy_q;
    assign bus_oe   = oe_q;
    assign bus_out  = out_q;
    assign bus_ctrl = ctrl_q;
    assign mdone    = mdone_q;
    assign merr     = merr_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_bus_ser_master.sv
// Scoreboard bench for bus_ser_master: expected beats and completions are queued by stimulus,
// a monitor pops and compares them as the DUT presents rdy rises and mdone rises.
// A second instance with TIMEOUT=4 and a silent slave covers the abort path.
module tb_bus_ser_master;
    import bus_pkg::*;

    typedef struct {
        logic [2:0] ctrl;
        logic [7:0] dat;
        logic       oe;
    } beat_t;

    typedef struct {
        logic       err;
        logic [7:0] rd;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  mtype;
    logic        mreq, mreq_t;
    logic [7:0]  bus_in = 8'h00;
    logic        ack = 1'b0;
    logic        mdone, merr, bus_oe, rdy;
    logic [7:0]  rdata, bus_out;
    logic [2:0]  bus_ctrl;
    logic        mdone_t, merr_t, bus_oe_t, rdy_t;
    logic [7:0]  rdata_t, bus_out_t;
    logic [2:0]  bus_ctrl_t;

    int    total = 0;
    int    bad = 0;
    beat_t exp_beats[$];
    done_t exp_done[$];
    logic  slave_en = 1'b1;
    int    ack_hold = 1;
    int    hold_cnt = 0;
    logic [7:0] rd_val = 8'h00;

    always #5 clk = ~clk;

    bus_ser_master dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mtype(mtype), .mreq(mreq),
        .mdone(mdone), .merr(merr), .rdata(rdata), .bus_out(bus_out), .bus_oe(bus_oe),
        .bus_in(bus_in), .rdy(rdy), .ack(ack), .bus_ctrl(bus_ctrl)
    );

    bus_ser_master #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mtype(mtype), .mreq(mreq_t),
        .mdone(mdone_t), .merr(merr_t), .rdata(rdata_t), .bus_out(bus_out_t), .bus_oe(bus_oe_t),
        .bus_in(bus_in), .rdy(rdy_t), .ack(1'b0), .bus_ctrl(bus_ctrl_t)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic pb(input logic [2:0] c, input logic [7:0] d, input logic oe);
        beat_t b;
        b.ctrl = c;
        b.dat  = d;
        b.oe   = oe;
        exp_beats.push_back(b);
    endtask

    task automatic pd(input logic err, input logic [7:0] rd);
        done_t d;
        d.err = err;
        d.rd  = rd;
        exp_done.push_back(d);
    endtask

    // Counts posedges from the one that first samples mreq high up to the one that raises mdone
    task automatic wait_mdone(output int lat);
        lat = 0;
        while (lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            if (mdone) break;
        end
        if (!mdone) begin
            total++;
            bad++;
            $display("FAIL mdone_wait: no mdone within %0d cycles", lat);
        end
    endtask

    task automatic wait_rdy(input logic [2:0] ctrl);
        int n;
        n = 0;
        while (!(rdy && bus_ctrl == ctrl) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(rdy && bus_ctrl == ctrl)) begin
            total++;
            bad++;
            $display("FAIL rdy_wait: no beat with ctrl %0b, got ctrl %0b", ctrl, bus_ctrl);
        end
    endtask

    task automatic run_txn(input logic [23:0] a, input logic [7:0] d, input logic [1:0] t, output int lat);
        @(negedge clk);
        addr  = a;
        wdata = d;
        mtype = t;
        mreq  = 1'b1;
        wait_mdone(lat);
    endtask

    task automatic end_txn(input string name);
        @(negedge clk);
        mreq = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_mdone_clr"}, 32'(mdone), 0);
        check({name, "_merr_clr"}, 32'(merr), 0);
    endtask

    // Slave model: ack one cycle after rdy, hold ack for ack_hold cycles, return rd_val on reads
    always @(negedge clk) begin
        if (slave_en) begin
            if (ack) begin
                hold_cnt = hold_cnt + 1;
                if (hold_cnt >= ack_hold) begin
                    ack      = 1'b0;
                    hold_cnt = 0;
                end
            end else if (rdy) begin
                ack    = 1'b1;
                bus_in = rd_val;
            end
        end
    end

    // Monitor: compare each new beat and each completion against the queued expectations
    logic        rdy_prev = 1'b0;
    logic        mdone_prev = 1'b0;
    logic [10:0] cur_key = '0;
    beat_t       eb;
    done_t       ed;
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (rdy && !rdy_prev) begin
                check("ack_low_at_rdy", 32'(ack), 0);
                if (exp_beats.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: ctrl=%0b out=0x%0h", bus_ctrl, bus_out);
                end else begin
                    eb = exp_beats.pop_front();
                    check("beat_ctrl", 32'(bus_ctrl), 32'(eb.ctrl));
                    check("beat_oe", 32'(bus_oe), 32'(eb.oe));
                    if (eb.oe) check("beat_out", 32'(bus_out), 32'(eb.dat));
                end
                cur_key = {bus_ctrl, bus_out};
            end else if (rdy) begin
                check("beat_stable", 32'({bus_ctrl, bus_out}), 32'(cur_key));
            end
            if (mdone && !mdone_prev) begin
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: merr=%0b rdata=0x%0h", merr, rdata);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_merr", 32'(merr), 32'(ed.err));
                    check("done_rdata", 32'(rdata), 32'(ed.rd));
                end
            end
        end
        rdy_prev   = rdy;
        mdone_prev = mdone;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, nrdy;
        logic [2:0] ctrl_seen;
        rst_n  = 1'b0;
        mreq   = 1'b0;
        mreq_t = 1'b0;
        addr   = '0;
        wdata  = '0;
        mtype  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(rdy), 0);
        check("rst_oe", 32'(bus_oe), 0);
        check("rst_out", 32'(bus_out), 0);
        check("rst_ctrl", 32'(bus_ctrl), 0);
        check("rst_mdone", 32'(mdone), 0);
        check("rst_merr", 32'(merr), 0);
        check("rst_rdata", 32'(rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: WDATA, all address bytes LSB first, then the write beat
        pb(3'b000, 8'h56, 1'b1);
        pb(3'b001, 8'h34, 1'b1);
        pb(3'b010, 8'h12, 1'b1);
        pb(3'b101, 8'hA5, 1'b1);
        pd(1'b0, 8'h00);
        run_txn(24'h123456, 8'hA5, MT_WDATA, lat);
        check("t1_latency", 32'(lat), 10);
        end_txn("t1");

        // Test 2: RCHAR, single read beat
        rd_val = 8'h3C;
        pb(3'b110, 8'h00, 1'b0);
        pd(1'b0, 8'h3C);
        run_txn(24'h000000, 8'h00, MT_RCHAR, lat);
        check("t2_latency", 32'(lat), 4);
        end_txn("t2");

        // Test 3: TIMEOUT=4 instance, slave never acks
        @(negedge clk);
        addr   = 24'h123456;
        mtype  = MT_WDATA;
        mreq_t = 1'b1;
        n = 0;
        nrdy = 0;
        ctrl_seen = 3'b111;
        while (!mdone_t && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (rdy_t) begin
                if (nrdy == 0) ctrl_seen = bus_ctrl_t;
                nrdy++;
            end
        end
        check("t3_rdy_cycles", 32'(nrdy), 4);
        check("t3_first_ctrl", 32'(ctrl_seen), 0);
        check("t3_mdone", 32'(mdone_t), 1);
        check("t3_merr", 32'(merr_t), 1);
        check("t3_rdy_low", 32'(rdy_t), 0);
        check("t3_oe_low", 32'(bus_oe_t), 0);
        check("t3_rdata", 32'(rdata_t), 0);
        @(negedge clk);
        mreq_t = 1'b0;
        @(posedge clk);
        #1;
        check("t3_mdone_clr", 32'(mdone_t), 0);
        check("t3_merr_clr", 32'(merr_t), 0);

        // Test 4: two RDATAs differing only in byte 0
        rd_val = 8'h77;
        pb(3'b000, 8'h10, 1'b1);
        pb(3'b001, 8'h00, 1'b1);
        pb(3'b010, 8'h00, 1'b1);
        pb(3'b100, 8'h00, 1'b0);
        pd(1'b0, 8'h77);
        run_txn(24'h000010, 8'h00, MT_RDATA, lat);
        check("t4a_latency", 32'(lat), 10);
        end_txn("t4a");
        rd_val = 8'h88;
        pb(3'b000, 8'h11, 1'b1);
`ifdef BUSCTL_ADDR_CACHE_EN
        pb(3'b100, 8'h00, 1'b0);
        pd(1'b0, 8'h88);
        run_txn(24'h000011, 8'h00, MT_RDATA, lat);
        check("t4b_latency", 32'(lat), 6);
`else
        pb(3'b001, 8'h00, 1'b1);
        pb(3'b010, 8'h00, 1'b1);
        pb(3'b100, 8'h00, 1'b0);
        pd(1'b0, 8'h88);
        run_txn(24'h000011, 8'h00, MT_RDATA, lat);
        check("t4b_latency", 32'(lat), 10);
`endif
        end_txn("t4b");

        // Test 5: slave holds ack for 6 cycles per beat; each beat costs 7 cycles
        ack_hold = 6;
        pb(3'b000, 8'hEF, 1'b1);
        pb(3'b001, 8'hCD, 1'b1);
        pb(3'b010, 8'hAB, 1'b1);
        pb(3'b101, 8'h5A, 1'b1);
        pd(1'b0, 8'h88);
        run_txn(24'hABCDEF, 8'h5A, MT_WDATA, lat);
        check("t5_latency", 32'(lat), 30);
        end_txn("t5");
        ack_hold = 1;

        // Test 5b: reset asserted while a beat is presented
        slave_en = 1'b0;
        pb(3'b000, 8'h01, 1'b1);
        @(negedge clk);
        addr  = 24'h000001;
        mtype = MT_RDATA;
        mreq  = 1'b1;
        wait_rdy(3'b000);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_rdy", 32'(rdy), 0);
        check("mid_rst_oe", 32'(bus_oe), 0);
        check("mid_rst_out", 32'(bus_out), 0);
        check("mid_rst_ctrl", 32'(bus_ctrl), 0);
        check("mid_rst_mdone", 32'(mdone), 0);
        check("mid_rst_merr", 32'(merr), 0);
        check("mid_rst_rdata", 32'(rdata), 0);
        @(negedge clk);
        mreq = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        slave_en = 1'b1;

        // Test 6a: mreq drops during the data beat; mdone pulses for one cycle
        pb(3'b000, 8'h00, 1'b1);
        pb(3'b001, 8'h01, 1'b1);
        pb(3'b010, 8'h00, 1'b1);
        pb(3'b101, 8'h3F, 1'b1);
        pd(1'b0, 8'h00);
        @(negedge clk);
        addr  = 24'h000100;
        wdata = 8'h3F;
        mtype = MT_WDATA;
        mreq  = 1'b1;
        wait_rdy(3'b101);
        @(negedge clk);
        mreq = 1'b0;
        wait_mdone(lat);
        n = 0;
        while (mdone && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("t6a_mdone_width", 32'(n), 1);

        // Test 6b: a second mreq rising edge during BEAT starts nothing
        slave_en = 1'b0;
        rd_val   = 8'h99;
        pb(3'b110, 8'h00, 1'b0);
        pd(1'b0, 8'h99);
        @(negedge clk);
        mtype = MT_RCHAR;
        mreq  = 1'b1;
        wait_rdy(3'b110);
        @(negedge clk);
        mreq = 1'b0;
        @(negedge clk);
        mreq     = 1'b1;
        slave_en = 1'b1;
        wait_mdone(lat);
        repeat (3) @(posedge clk);
        #1;
        check("t6b_mdone_held", 32'(mdone), 1);
        end_txn("t6b");
        repeat (10) @(posedge clk);
        #1;
        check("t6b_idle_rdy", 32'(rdy), 0);

        check("beats_left", 32'(exp_beats.size()), 0);
        check("dones_left", 32'(exp_done.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_ser_master.md
# bus_ser_master

Parametrised successor to the CPU bus controller. Serialises a CPU memory or character-I/O request onto a narrow external bus as address beats plus one data beat. Every beat uses a four-phase rdy/ack handshake. Adds read-data return, an ack timeout with error reporting, and optional skipping of unchanged address bytes. Sits between the bf CPU core (mreq/mdone side) and the chip's bidirectional bus pins.

## Interface
- BUS_W, 8, bus/data width in bits
- ADDR_W, 24, address width; must be a multiple of BUS_W; NA = ADDR_W/BUS_W, 1..4
- TIMEOUT, 255, max wait cycles per handshake phase; 0 disables the timeout
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- addr  in  ADDR_W  address; sampled on mreq rising edge
- wdata  in  BUS_W  write data; sampled on mreq rising edge
- mtype  in  2  transaction type, sampled on mreq rising edge: 0 RDATA, 1 WDATA, 2 RCHAR, 3 WCHAR
- mreq  in  1  request; a rising edge starts a transaction; held high until mdone
- mdone  out  1  transaction finished; held until mreq is sampled low
- merr  out  1  transaction aborted by timeout; valid while mdone is high
- rdata  out  BUS_W  read result of RDATA/RCHAR; held until the next read completes
- bus_out  out  BUS_W  value driven to the pins
- bus_oe  out  1  pin output enable
- bus_in  in  BUS_W  value sampled from the pins
- rdy  out  1  beat presented to the slave
- ack  in  1  slave completed the beat
- bus_ctrl  out  3  beat kind: 0xx = address byte index xx; 100 RDATA, 101 WDATA, 110 RCHAR, 111 WCHAR; 000 when idle

## Operation
- States: IDLE, PREP, BEAT, RELEASE, DONE.
- Reset: state IDLE; these outputs are 0: rdy, bus_oe, bus_out, bus_ctrl, mdone, merr, rdata.
- Edge detection: mreq_dly is a register; the rising edge is mreq & ~mreq_dly.
- IDLE: on a rising edge, latch addr, wdata and mtype, then go to PREP. A rising edge outside IDLE is ignored.
- Beat list:
  - RDATA/WDATA: address bytes 0..NA-1, least-significant byte first, then one data beat.
  - RCHAR/WCHAR: the data beat only.
- PREP: wait for ack = 0, then load the first beat and go to BEAT.
- BEAT: rdy=1, with bus_ctrl and bus_out set for the beat.
  - bus_oe=1 for address and write beats; 0 for read beats.
  - On ack=1: for a read beat, capture bus_in into rdata; go to RELEASE.
- RELEASE: rdy=0, bus_oe=0.
  - On ack=0, load the next beat and go to BEAT.
  - After the last beat, go to DONE instead.
- DONE: mdone=1. When mreq is sampled 0, clear mdone and merr and go to IDLE.
  - If mreq fell mid-transaction, the transaction still completes; mdone is then high for exactly 1 cycle.
- Timeout (TIMEOUT>0):
  - A wait counter clears on every entry to PREP, BEAT or RELEASE.
  - If the counter reaches TIMEOUT while ack keeps the state from advancing:
    - set rdy=0 and bus_oe=0;
    - set merr=1 and mdone=1;
    - go to DONE;
    - rdata is unchanged.
- Counter width is clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- mreq first sampled high at edge t gives PREP at t+1. With ack low, rdy=1 at t+2.
- ack sampled high at edge t gives rdy=0 at t+1. rdata is updated at t+1 for read beats.
- ack sampled low in RELEASE at t gives the next beat (rdy=1) or mdone=1 at t+1.
- Minimum transaction, with an ideal slave acking and releasing in 1 cycle: 2 + 2·(beats) cycles from the mreq edge to mdone.
- bus_out and bus_ctrl are stable for the whole of BEAT and change only when entering BEAT.

## Configuration
- BUSCTL_ADDR_CACHE_EN defined:
  - Keep a register of the last-sent address bytes with one valid bit per byte.
  - In RDATA/WDATA, skip an address byte when it is valid and equal to the cached byte.
  - The data beat is never skipped. If every address byte matches, only the data beat runs.
  - Valid bits clear on reset and on any timeout. A byte is cached when its beat's ack is seen.
- Not defined: all NA address bytes are sent on every RDATA/WDATA. There is no cache storage.

## Structure
- Shared package bus_pkg holds:
  - mtype encodings (RDATA, WDATA, RCHAR, WCHAR);
  - bus_ctrl encodings;
  - the state enum.
- CPU, bus controller and test benches all use bus_pkg.
- One sub-module, bus_beat_seq, sequences the beat list: next-beat index, last-beat flag and cache skip logic. The top module holds the handshake FSM, timeout and datapath.

## Test plan
- Test 1, WDATA with defaults: addr=0x123456, wdata=0xA5, slave acks each beat after 1 cycle.
  - Beats in order: ctrl 000/0x56, 001/0x34, 010/0x12, 101/0xA5, each with bus_oe=1.
  - mdone at the 10th cycle after the edge; merr=0.
- Test 2, RCHAR: slave drives bus_in=0x3C with ack.
  - A single beat with ctrl 110 and bus_oe=0.
  - rdata=0x3C; no address beats.
- Test 3, timeout: TIMEOUT=4, slave never acks the first address beat.
  - rdy drops after 4 wait cycles in BEAT; mdone=1 and merr=1.
  - mreq low then clears both.
- Test 4, cache (BUSCTL_ADDR_CACHE_EN): RDATA at 0x000010, then RDATA at 0x000011.
  - The second transaction issues only ctrl 000/0x11, then 100.
  - Without the macro, 4 beats again.
- Test 5, late ack release: slave holds ack high for 6 cycles.
  - No new rdy until ack is sampled low.
  - Reset (rst_n=0) asserted mid-BEAT returns all outputs to 0 on the next edge.
- Test 6, mreq handling: mreq drops during the WDATA beat.
  - The transaction completes; mdone is high for 1 cycle.
  - A second rising edge of mreq during BEAT is ignored.
